fx2_stream_writer: RTL and testbench
====================================

// Module: fx2_stream_writer
// PURPOSE
//  Parametrised FX2LP slave-FIFO write engine. It replaces the fixed 4-byte IQ serializer.
//  - Accepts NUM_CH samples of SAMPLE_WIDTH bits per input beat and buffers them in an internal word FIFO.
//  - Serialises each word LSB-byte-first onto FD, honouring the FX2 full flag on every byte.
//  - Commits short packets with PKTEND after an idle timeout.
//  - Sits between the decimation chain (CIC/FIR outputs) and the FX2LP pins.
// PARAMETERS
//  SAMPLE_WIDTH   16    bits per channel sample; NUM_CH*SAMPLE_WIDTH must be a multiple of 8
//  NUM_CH         2     channels per beat; channel 0 occupies in_data[SAMPLE_WIDTH-1:0]
//  FIFO_DEPTH     16    words in the internal buffer; power of 2, >= 2
//  PKT_BYTES      512   FX2 endpoint packet size in bytes; power of 2
//  FLUSH_TIMEOUT  4096  idle clocks before a partial packet is committed; 0 disables flushing
// PORTS
//  clk           in   1                    stream clock (IFCLK domain); all registers on its rising edge
//  reset         in   1                    asynchronous, active-high reset
//  enable        in   1                    1 = accept input beats
//  swap          in   1                    1 = reverse channel order within the word
//  in_data       in   NUM_CH*SAMPLE_WIDTH  sample beat
//  in_valid      in   1                    beat qualifier; there is no backpressure to the source
//  full_n        in   1                    FX2 FLAGB, active-low "endpoint full"
//  fd            out  8                    FX2 data bus byte
//  slwr_n        out  1                    FX2 write strobe, active low
//  pktend_n      out  1                    FX2 packet-end strobe, active low
//  fifo_level    out  clog2(FIFO_DEPTH)+1  current internal FIFO occupancy
//  ovf_count     out  16                   dropped-beat counter, saturating
//  ovf_clr       in   1                    synchronous clear of ovf_count
//  busy          out  1                    1 while in the SEND or PKTEND state, or while the FIFO is non-empty
// BEHAVIOUR
//  Reset values
//  - fd = 0, slwr_n = 1, pktend_n = 1.
//  - FIFO empty, fifo_level = 0, ovf_count = 0, byte counter = 0, idle timer = 0, state = IDLE.
//  - Reset mid-packet aborts at once. Partial words and bytes are discarded and no PKTEND is issued.
//  Input path
//  - A beat is written when in_valid && enable && FIFO not full.
//  - If in_valid && enable && FIFO full, the beat is dropped and ovf_count increments, saturating at 16'hFFFF.
//  - ovf_clr has priority over an increment in the same cycle. Beats with enable = 0 are ignored and not counted.
//  - swap is sampled at FIFO write time. With swap = 1, channel k is stored in slot NUM_CH-1-k.
//  Output FSM (BPW = NUM_CH*SAMPLE_WIDTH/8 bytes per word)
//  - IDLE: if the FIFO is non-empty, pop the word, set byte index to 0, go to SEND.
//    Otherwise, if FLUSH_TIMEOUT != 0, byte counter != 0 and idle timer == FLUSH_TIMEOUT-1, go to PKTEND.
//  - SEND: fd = current byte. slwr_n is low only in cycles where full_n = 1; when full_n = 0, fd and the index hold.
//    - Each write increments the byte index and the packet byte counter (mod PKT_BYTES).
//    - After byte BPW-1 is written: pop the next word and continue without a gap if one is available, else go to IDLE.
//  - PKTEND: pktend_n is low for exactly one cycle in which full_n = 1 (wait while full_n = 0).
//    The byte counter then clears and the FSM returns to IDLE.
//  Timing and counters
//  - Latency: a beat accepted at edge N into an empty, idle block gives slwr_n low with byte 0 in the cycle after edge N+2.
//  - Idle timer: clears on any write or on leaving PKTEND; otherwise increments in IDLE while the FIFO is empty;
//    it saturates at FLUSH_TIMEOUT-1.
//  - Byte counter wrapping to 0 at PKT_BYTES means the FX2 auto-committed the packet; no PKTEND is issued then.
//  - A FIFO write and pop in the same cycle leave fifo_level unchanged. A beat arriving while in PKTEND is queued normally.
//  - slwr_n and pktend_n are never low in the same cycle.
// TESTING
//  T1 NUM_CH=2, SW=16, full_n=1; one beat 0xBBBB_AAAA -> fd 0xAA,0xAA,0xBB,0xBB on 4 consecutive slwr_n-low cycles,
//     first one 2 clocks after acceptance.
//  T2 swap=1, same beat -> byte order 0xBB,0xBB,0xAA,0xAA; ovf_count stays 0.
//  T3 full_n=0 for 5 cycles after byte 1 -> slwr_n high and fd frozen for those 5 cycles, then bytes 2-3 sent; no byte lost or repeated.
//  T4 FLUSH_TIMEOUT=8; 3 beats (12 bytes) then idle -> exactly one pktend_n pulse 8 clocks after the last write.
//     128 beats (512 bytes) then idle -> no pktend_n pulse.
//  T5 full_n=0 held, 20 beats with FIFO_DEPTH=16 -> fifo_level=16, ovf_count=4.
//     ovf_clr asserted together with a further drop -> ovf_count=0.
//  T6 reset asserted mid-word -> outputs take reset values asynchronously.
//     After release, a fresh beat is sent intact from byte 0.

Source files
------------

// File: rtl/fx2_stream_writer.sv
// fx2_stream_writer: FX2LP slave-FIFO write engine.
// Packs NUM_CH samples per beat into a word FIFO, then serialises each word
// LSB-byte-first onto fd under the FX2 full flag, and commits short packets
// with pktend_n after FLUSH_TIMEOUT idle clocks.
module fx2_stream_writer #(
    parameter int SAMPLE_WIDTH  = 16,
    parameter int NUM_CH        = 2,
    parameter int FIFO_DEPTH    = 16,
    parameter int PKT_BYTES     = 512,
    parameter int FLUSH_TIMEOUT = 4096
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             swap,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0]   in_data,
    input  logic                             in_valid,
    input  logic                             full_n,
    output logic [7:0]                       fd,
    output logic                             slwr_n,
    output logic                             pktend_n,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic [15:0]                      ovf_count,
    input  logic                             ovf_clr,
    output logic                             busy
);

    localparam int WORD_W = NUM_CH * SAMPLE_WIDTH;
    localparam int BPW    = WORD_W / 8;
    localparam int LW     = $clog2(FIFO_DEPTH);
    localparam int IDX_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int BC_W   = $clog2(PKT_BYTES);
    localparam int TW     = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);
    localparam logic [TW-1:0]    TMAX     = TW'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);
    localparam logic [LW:0]      LVL_FULL = (LW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_PKTEND
    } state_t;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [LW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW:0]       level_q;
    logic              wrote_q;
    logic [WORD_W-1:0] wr_word;
    logic              beat, push, drop, pop, avail;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [15:0]       ovf_q;

    assign beat  = in_valid && enable;
    assign push  = beat && (level_q != LVL_FULL);
    assign drop  = beat && (level_q == LVL_FULL);
    // A word written on the last edge becomes readable one cycle later, like a
    // registered-write RAM; this gives the two-clock beat-to-strobe latency.
    assign avail = (level_q - {{LW{1'b0}}, wrote_q}) != '0;

    // Place each channel in its slot, reversed when swap is set.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (swap)
                wr_word[(NUM_CH-1-k)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = in_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            else
                wr_word[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = in_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
    end

    // Word storage.
    // NOTE: the storage array has no reset; validity is tracked by the pointers and level, which are reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_word;
    end

    // FIFO pointers, occupancy and the drop counter.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            wrote_q  <= 1'b0;
            ovf_q    <= '0;
        end else begin
            wrote_q <= push;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (ovf_clr)
                ovf_q <= '0;
            else if (drop && (ovf_q != 16'hFFFF))
                ovf_q <= ovf_q + 1'b1;
        end
    end

    // Output FSM: next state, strobes, byte index, packet counter and idle timer.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        timer_d  = timer_q;
        pop      = 1'b0;
        slwr_n   = 1'b1;
        pktend_n = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (avail) begin
                    pop     = 1'b1;
                    word_d  = mem[rd_ptr_q];
                    idx_d   = '0;
                    state_d = S_SEND;
                end else if (level_q == '0) begin
                    if (timer_q != TMAX) timer_d = timer_q + 1'b1;
                    if ((FLUSH_TIMEOUT != 0) && (bcnt_q != '0) && (timer_q == TMAX))
                        state_d = S_PKTEND;
                end
            end
            S_SEND: begin
                if (full_n) begin
                    slwr_n  = 1'b0;
                    bcnt_d  = bcnt_q + 1'b1;
                    timer_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (avail) begin
                            pop    = 1'b1;
                            word_d = mem[rd_ptr_q];
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PKTEND: begin
                if (full_n) begin
                    pktend_n = 1'b0;
                    bcnt_d   = '0;
                    timer_d  = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output FSM registers; reset aborts any word or packet in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            timer_q <= timer_d;
        end
    end

    assign fd         = word_q[8*idx_q +: 8];
    assign fifo_level = level_q;
    assign ovf_count  = ovf_q;
    assign busy       = (state_q != S_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_fx2_stream_writer.sv
// Directed bench for fx2_stream_writer (2 x 16-bit channels, 16-word FIFO,
// 512-byte packets, flush after 8 idle clocks).
module tb_fx2_stream_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        swap = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        full_n = 1'b1;
    logic        ovf_clr = 1'b0;
    logic [7:0]  fd;
    logic        slwr_n;
    logic        pktend_n;
    logic [4:0]  fifo_level;
    logic [15:0] ovf_count;
    logic        busy;

    int tests = 0;
    int fails = 0;

    fx2_stream_writer #(
        .SAMPLE_WIDTH (16),
        .NUM_CH       (2),
        .FIFO_DEPTH   (16),
        .PKT_BYTES    (512),
        .FLUSH_TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .swap      (swap),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .full_n    (full_n),
        .fd        (fd),
        .slwr_n    (slwr_n),
        .pktend_n  (pktend_n),
        .fifo_level(fifo_level),
        .ovf_count (ovf_count),
        .ovf_clr   (ovf_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Cycle index: the cycle following rising edge k carries cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor, sampled mid-cycle on the falling edge.
    logic [7:0] wq[$];
    int         wcyc[$];
    int         pkt_cnt = 0;
    int         pkt_cyc = 0;
    bit         both_low = 1'b0;
    always @(negedge clk) begin
        if (slwr_n === 1'b0) begin
            wq.push_back(fd);
            wcyc.push_back(cyc);
        end
        if (pktend_n === 1'b0) begin
            pkt_cnt = pkt_cnt + 1;
            pkt_cyc = cyc;
        end
        if ((slwr_n === 1'b0) && (pktend_n === 1'b0)) both_low = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] data);
        in_data  = data;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Four bytes of one word, LSB first, starting at queue position b0.
    task automatic check_stream(input string tag, input int b0, input logic [31:0] word);
        check({tag, "_count"}, wq.size() - b0, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_byte%0d", tag, i), wq[b0 + i], word[8*i +: 8]);
    endtask

    initial begin
        int b0, p0, acc, bad;

        // Reset values
        repeat (3) tick();
        check("rst_fd", fd, 8'h00);
        check("rst_slwr_n", slwr_n, 1'b1);
        check("rst_pktend_n", pktend_n, 1'b1);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", ovf_count, 0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick();

        // T1: plain byte order, latency, and a flush 8 idle clocks later
        b0 = wq.size();
        p0 = pkt_cnt;
        send_beat(32'hBBBB_AAAA);
        acc = cyc;
        check("t1_level", fifo_level, 1);
        check("t1_busy", busy, 1'b1);
        repeat (25) tick();
        check_stream("t1", b0, 32'hBBBB_AAAA);
        check("t1_latency", wcyc[b0] - acc, 2);
        check("t1_back_to_back", wcyc[b0 + 3] - wcyc[b0], 3);
        check("t1_pktend_count", pkt_cnt - p0, 1);
        // Eight idle cycles separate the last strobe cycle from the pktend cycle.
        check("t1_pktend_delay", pkt_cyc - wcyc[b0 + 3], 9);

        // T2: channel swap
        b0 = wq.size();
        swap = 1'b1;
        send_beat(32'hBBBB_AAAA);
        swap = 1'b0;
        repeat (25) tick();
        check_stream("t2", b0, 32'hAAAA_BBBB);
        check("t2_ovf", ovf_count, 0);

        // T3: endpoint full for 5 cycles after byte 1
        b0 = wq.size();
        send_beat(32'h4433_2211);
        repeat (4) tick();
        full_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t3_stall_slwr_n%0d", i), slwr_n, 1'b1);
            check($sformatf("t3_stall_fd%0d", i), fd, 8'h33);
            tick();
        end
        full_n = 1'b1;
        repeat (25) tick();
        check_stream("t3", b0, 32'h4433_2211);

        // T4a: 12 bytes then idle -> one pktend
        b0 = wq.size();
        p0 = pkt_cnt;
        in_valid = 1'b1;
        in_data = 32'h0302_0100; tick();
        in_data = 32'h0706_0504; tick();
        in_data = 32'h0B0A_0908; tick();
        in_valid = 1'b0;
        repeat (30) tick();
        check("t4a_count", wq.size() - b0, 12);
        bad = 0;
        for (int j = 0; j < 12; j++) if (wq[b0 + j] !== 8'(j)) bad++;
        check("t4a_bytes_bad", bad, 0);
        check("t4a_pktend_count", pkt_cnt - p0, 1);
        check("t4a_pktend_delay", pkt_cyc - wcyc[b0 + 11], 9);

        // T4b: exactly one full packet -> no pktend
        b0 = wq.size();
        p0 = pkt_cnt;
        for (int i = 0; i < 128; i++) begin
            in_data = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            repeat (3) tick();
        end
        repeat (30) tick();
        check("t4b_count", wq.size() - b0, 512);
        bad = 0;
        for (int j = 0; j < 512; j++) if (wq[b0 + j] !== 8'(j)) bad++;
        check("t4b_bytes_bad", bad, 0);
        check("t4b_pktend_count", pkt_cnt - p0, 0);

        // T5: endpoint held full. A first beat is parked in the output word
        // register, so the following 20 beats fill the 16-word FIFO and drop 4.
        full_n = 1'b0;
        send_beat(32'h1234_5678);
        repeat (4) tick();
        check("t5_parked_level", fifo_level, 0);
        b0 = wq.size();
        in_data = 32'hCAFE_F00D;
        in_valid = 1'b1;
        repeat (20) tick();
        in_valid = 1'b0;
        check("t5_level", fifo_level, 16);
        check("t5_ovf", ovf_count, 4);
        ovf_clr = 1'b1;
        in_valid = 1'b1;
        tick();
        ovf_clr = 1'b0;
        in_valid = 1'b0;
        check("t5_ovf_clr_priority", ovf_count, 0);
        send_beat(32'hCAFE_F00D);
        check("t5_ovf_after_drop", ovf_count, 1);
        enable = 1'b0;
        send_beat(32'hCAFE_F00D);
        enable = 1'b1;
        check("t5_ovf_disabled", ovf_count, 1);
        check("t5_no_writes", wq.size() - b0, 0);
        check("t5_busy", busy, 1'b1);

        // T6: asynchronous reset in the middle of a word
        b0 = wq.size();
        full_n = 1'b1;
        for (int k = 0; k < 50 && wq.size() < b0 + 2; k++) tick();
        check("t6_bytes_before_reset", wq.size() - b0, 2);
        check("t6_byte0", wq[b0], 8'h78);
        check("t6_byte1", wq[b0 + 1], 8'h56);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_fd", fd, 8'h00);
        check("t6_rst_slwr_n", slwr_n, 1'b1);
        check("t6_rst_pktend_n", pktend_n, 1'b1);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_ovf", ovf_count, 0);
        check("t6_rst_busy", busy, 1'b0);
        p0 = pkt_cnt;
        b0 = wq.size();
        tick();
        reset = 1'b0;
        repeat (20) tick();
        check("t6_no_pktend", pkt_cnt - p0, 0);
        check("t6_no_stray_bytes", wq.size() - b0, 0);
        send_beat(32'hDDCC_BBAA);
        acc = cyc;
        repeat (25) tick();
        check_stream("t6", b0, 32'hDDCC_BBAA);
        check("t6_latency", wcyc[b0] - acc, 2);

        check("strobes_never_both_low", both_low, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
